imem_loader: RTL and testbench
==============================

# imem_loader

Byte-serial program loader that writes the instruction memory the PC fetch path reads. It sits between an 8-bit byte source (host/UART front end) and the instruction memory write port. It assembles incoming bytes big-endian into 32-bit MIPS instruction words and writes them to consecutive word addresses starting at 0x00. It holds the CPU in reset via `cpu_hold` until the program is fully loaded.

## Interface
- `MAX_WORDS`, 64, instruction memory depth in words; byte address space is 8 bits, matching the PC width.
- `clk`  input  1  single clock; all state changes on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle request to begin a load; sampled only in IDLE, DONE or ERROR.
- `num_words`  input  7  number of words to load, sampled in the cycle `start` is accepted; legal range 0..MAX_WORDS.
- `byte_in`  input  8  incoming program byte.
- `byte_valid`  input  1  `byte_in` is valid.
- `byte_ready`  output  1  loader accepts a byte this cycle.
- `imem_we`  output  1  instruction memory write strobe.
- `imem_addr`  output  8  byte address of the write, always word-aligned (bits [1:0] = 0).
- `imem_wdata`  output  32  instruction word to write.
- `cpu_hold`  output  1  keeps PC/datapath in reset while high.
- `done`  output  1  load complete; program valid.
- `error`  output  1  illegal `num_words` requested.

## Operation
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE: `cpu_hold`=1, `byte_ready`=0. On `start`:
  - `num_words`=0 -> DONE.
  - `num_words`>MAX_WORDS -> ERROR.
  - otherwise latch the count, clear the word index and byte counter, and go to RECV.
- RECV: `byte_ready`=1. A byte is accepted when `byte_valid` and `byte_ready` are both high.
  - Accepted bytes shift in MSB-first: byte 0 -> [31:24], byte 3 -> [7:0].
  - A 2-bit byte counter wraps 3->0; the 4th accepted byte moves to WRITE.
  - Cycles with `byte_valid`=0 stall with no state change.
- WRITE: exactly one cycle.
  - `imem_we`=1, `imem_addr`={word_idx,2'b00}, `imem_wdata`=assembled word, `byte_ready`=0.
  - Then word_idx increments. If the written word was the last (word_idx == count-1) go to DONE, else go to RECV.
- DONE: `done`=1, `cpu_hold`=0. `start` restarts exactly as from IDLE and drops `done` and raises `cpu_hold` on the next cycle.
- ERROR: `error`=1, `cpu_hold`=1. `start` is evaluated as in IDLE.
- `start` in RECV or WRITE is ignored.
- `imem_we` is high only in WRITE. `imem_addr` and `imem_wdata` hold their last values otherwise.
- Address never exceeds (MAX_WORDS-1)*4 = 0xFC.

## Timing
- Reset values: state IDLE, `cpu_hold`=1, `done`=0, `error`=0, `byte_ready`=0, `imem_we`=0, `imem_addr`=0x00, `imem_wdata`=0, byte counter 0, word_idx 0.
- Reset mid-operation: the next cycle is IDLE, the partial word is discarded, no write is issued, and already-written words stay in memory.
- `start` accepted at cycle T -> RECV at T+1 (`byte_ready`=1 at T+1).
- 4th byte accepted at cycle T -> `imem_we`=1 at T+1 -> RECV or DONE at T+2.
- Minimum 5 cycles per word; N words with back-to-back bytes: DONE reached 5N+1 cycles after `start`.
- `cpu_hold` falls in the same cycle `done` rises.
- All outputs are registered or decoded from state only. No combinational path from `byte_valid` to `byte_ready`.

## Test plan
- Reset: assert `reset` 2 cycles mid-stream -> next cycle all outputs at reset values, `cpu_hold`=1, no `imem_we` pulse.
- Single word: `start`, `num_words`=1, bytes 0x20,0x08,0x00,0x05 back-to-back -> one `imem_we` pulse with addr 0x00, data 0x20080005. `done`=1 and `cpu_hold`=0 on the following cycle, 6 cycles after `start`.
- Three words with `byte_valid` gaps (random 0-3 idle cycles) for 0x8C090004, 0xAC0A0008, 0x1109FFFE -> writes at 0x00, 0x04, 0x08 with exact data. `byte_ready` low in every WRITE cycle; no extra writes.
- `num_words`=0 -> DONE one cycle after `start`, no write. `num_words`=65 -> `error`=1, `cpu_hold`=1, `byte_ready` stays 0.
- Full depth: `num_words`=64 -> last write at addr 0xFC, then DONE. Bytes offered after DONE are not accepted.
- Restart: `start` in DONE with `num_words`=2 -> `done` drops and `cpu_hold` rises next cycle, writes restart at 0x00. `start` pulsed during RECV is ignored (word count unchanged).

Source files
------------

// File: rtl/imem_loader.sv
// Byte-serial instruction memory loader: packs big-endian bytes into 32-bit words
// and writes them to word addresses 0x00, 0x04, ... while holding the CPU in reset.
// Latency: 4th byte accepted at T -> imem_we at T+1; N back-to-back words finish 5N+1 cycles after start.
// Backpressure: byte_ready is high only in RECV and depends on state alone; byte_valid low stalls.
// Ports: clk/reset (sync, active-high); start + num_words request a load;
//   byte_in/byte_valid/byte_ready byte stream; imem_we/imem_addr/imem_wdata write port;
//   cpu_hold, done, error status.
module imem_loader #(
  parameter int MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  num_words,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = $clog2(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t             state;
  state_t             nextState;
  logic [6:0]         wordCount;
  logic [IDX_W-1:0]   wordIdx;
  logic [1:0]         byteCnt;
  logic [23:0]        shiftReg;   // first three bytes of the word in flight
  logic               byteAccept;
  logic               loadStart;
  logic               lastWord;

  assign byteAccept = byte_valid && byte_ready;
  assign lastWord   = (7'(wordIdx) == (wordCount - 7'd1));

  // Status outputs are pure state decodes, so there is no path from byte_valid to byte_ready.
  assign byte_ready = (state == RECV);
  assign imem_we    = (state == WRITE);
  assign done       = (state == DONE);
  assign error      = (state == ERROR);
  assign cpu_hold   = (state != DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    loadStart = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          if (num_words == 7'd0) begin
            nextState = DONE;
          end else if (num_words > 7'(MAX_WORDS)) begin
            nextState = ERROR;
          end else begin
            nextState = RECV;
            loadStart = 1'b1;
          end
        end
      end
      RECV: begin
        if (byteAccept && (byteCnt == 2'd3)) begin
          nextState = WRITE;
        end
      end
      WRITE: begin
        nextState = lastWord ? DONE : RECV;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wordCount  <= 7'd0;
      wordIdx    <= '0;
      byteCnt    <= 2'd0;
      shiftReg   <= 24'd0;
      imem_addr  <= 8'd0;
      imem_wdata <= 32'd0;
    end else begin
      if (loadStart) begin
        wordCount <= num_words;
        wordIdx   <= '0;
        byteCnt   <= 2'd0;
      end
      if (byteAccept) begin
        byteCnt  <= byteCnt + 2'd1;
        shiftReg <= {shiftReg[15:0], byte_in};
        // Address and data are staged on the last byte so they are valid for the whole
        // WRITE cycle and simply hold afterwards.
        if (byteCnt == 2'd3) begin
          imem_wdata <= {shiftReg, byte_in};
          imem_addr  <= 8'({wordIdx, 2'b00});
        end
      end
      if (state == WRITE) begin
        wordIdx <= wordIdx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
// Expected {addr,data} pairs are queued as words are sent and matched on each imem_we.
// Reports one summary line of passed/total checks.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  num_words;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader #(.MAX_WORDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_words  (num_words),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checkCnt = 0;
  int          passCnt  = 0;
  int          writeCnt = 0;
  logic [7:0]  lastAddr = 8'd0;
  logic [39:0] expQ[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Write monitor, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      logic [39:0] e;
      writeCnt++;
      lastAddr = imem_addr;
      check("byte_ready_in_write", 32'(byte_ready), 32'd0);
      check("write_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e[39:32]));
        check("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic startLoad(input logic [6:0] n, output int s);
    s = cyc;
    start = 1'b1;
    num_words = n;
    step();
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("byte_accept_timeout", 32'(byte_ready), 32'd1);
    step();
    byte_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxGap);
    for (int i = 0; i < 4; i++) begin
      int gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
      repeat (gap) step();
      sendByte(w[31 - 8*i -: 8]);
    end
  endtask

  task automatic waitDone();
    int n = 0;
    while (done !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_error"},      32'(error),      32'd0);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_imem_we"},    32'(imem_we),    32'd0);
    check({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    check({tag, "_imem_wdata"}, imem_wdata,      32'd0);
  endtask

  initial begin
    int s;
    int w0;
    logic [31:0] fw;
    logic [31:0] three[3];
    three[0] = 32'h8C090004;
    three[1] = 32'hAC0A0008;
    three[2] = 32'h1109FFFE;

    reset = 1'b1;
    start = 1'b0;
    num_words = 7'd0;
    byte_in = 8'd0;
    byte_valid = 1'b0;
    step();
    step();
    checkResetOutputs("por");
    reset = 1'b0;
    step();
    checkResetOutputs("idle");

    // Single word, back-to-back bytes
    expQ.push_back({8'h00, 32'h20080005});
    startLoad(7'd1, s);
    check("single_ready_after_start", 32'(byte_ready), 32'd1);
    sendWord(32'h20080005, 0);
    waitDone();
    check("single_cycles", 32'(cyc - s), 32'd6);
    check("single_cpu_hold", 32'(cpu_hold), 32'd0);
    check("single_writes", 32'(writeCnt), 32'd1);

    // Reset mid-stream: first word written, second word partial
    expQ.push_back({8'h00, 32'hDEADBEEF});
    startLoad(7'd2, s);
    check("restart_hold", 32'(cpu_hold), 32'd1);
    sendWord(32'hDEADBEEF, 0);
    sendByte(8'h11);
    sendByte(8'h22);
    reset = 1'b1;
    step();
    checkResetOutputs("midrst");
    step();
    reset = 1'b0;
    step();
    check("midrst_writes", 32'(writeCnt), 32'd2);
    check("midrst_queue", 32'(expQ.size()), 32'd0);

    // Zero words
    startLoad(7'd0, s);
    check("zero_done", 32'(done), 32'd1);
    check("zero_cycles", 32'(cyc - s), 32'd1);
    check("zero_cpu_hold", 32'(cpu_hold), 32'd0);
    check("zero_writes", 32'(writeCnt), 32'd2);

    // Illegal count
    startLoad(7'd65, s);
    check("err_error", 32'(error), 32'd1);
    check("err_cpu_hold", 32'(cpu_hold), 32'd1);
    check("err_done", 32'(done), 32'd0);
    byte_valid = 1'b1;
    byte_in = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      check("err_byte_ready", 32'(byte_ready), 32'd0);
      step();
    end
    byte_valid = 1'b0;

    // Three words with random gaps, started from ERROR
    w0 = writeCnt;
    for (int i = 0; i < 3; i++) expQ.push_back({8'(i * 4), three[i]});
    startLoad(7'd3, s);
    check("three_error_cleared", 32'(error), 32'd0);
    for (int i = 0; i < 3; i++) sendWord(three[i], 3);
    waitDone();
    check("three_writes", 32'(writeCnt - w0), 32'd3);
    check("three_queue", 32'(expQ.size()), 32'd0);

    // Full depth
    w0 = writeCnt;
    for (int i = 0; i < 64; i++) begin
      fw = {8'(i), 8'hC3, 8'(~i), 8'(i * 3)};
      expQ.push_back({8'(i * 4), fw});
    end
    startLoad(7'd64, s);
    for (int i = 0; i < 64; i++) begin
      fw = {8'(i), 8'hC3, 8'(~i), 8'(i * 3)};
      sendWord(fw, 0);
    end
    waitDone();
    check("full_cycles", 32'(cyc - s), 32'd321);
    check("full_last_addr", 32'(lastAddr), 32'hFC);
    check("full_writes", 32'(writeCnt - w0), 32'd64);
    byte_valid = 1'b1;
    byte_in = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      check("after_done_byte_ready", 32'(byte_ready), 32'd0);
      step();
    end
    byte_valid = 1'b0;
    check("after_done_writes", 32'(writeCnt - w0), 32'd64);

    // Restart from DONE; start pulse during RECV ignored
    w0 = writeCnt;
    expQ.push_back({8'h00, 32'h01234567});
    expQ.push_back({8'h04, 32'h89ABCDEF});
    startLoad(7'd2, s);
    check("restart_done_drop", 32'(done), 32'd0);
    check("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    sendByte(8'h01);
    sendByte(8'h23);
    start = 1'b1;
    num_words = 7'd5;
    step();
    start = 1'b0;
    check("recv_start_ignored", 32'(byte_ready), 32'd1);
    sendByte(8'h45);
    sendByte(8'h67);
    sendWord(32'h89ABCDEF, 1);
    waitDone();
    check("restart_writes", 32'(writeCnt - w0), 32'd2);
    check("final_queue", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
